axi_cmd_arbiter: RTL and testbench

- AXI-side front end of the AXI-to-AHB bridge, clocked in the AXI (wclk) domain.
- Accepts AW and AR address-channel requests and arbitrates between them round-robin.
- Pushes each granted transaction's tag {is_write, id} into the downstream 9-bit ID send FIFO, and presents the address command to the AHB command path in the same cycle.
- Limits in-flight transactions so the ID FIFO and response tracking cannot overrun.

---
 rtl/axi_cmd_arbiter.sv | 134 +++++++++++++
 tb/tb_axi_cmd_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_arbiter.sv
// AXI address-channel front end: round-robin AW/AR arbitration, atomic command + ID-tag push, in-flight limiting.
// Optional build macro AXI_CMD_ARB_WR_PRIORITY_EN selects fixed write-over-read priority.
module axi_cmd_arbiter #(
  parameter int ID_W      = 8,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 16
) (
  input  logic              wclk,
  input  logic              resetn,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W:0]     id_data,
  output logic              id_write_en,
  input  logic              id_full,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [3:0]        cmd_len,
  output logic [2:0]        cmd_size,
  output logic [1:0]        cmd_burst,
  output logic              cmd_write,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic              txn_done,
  output logic [4:0]        outst_cnt
);

  typedef enum logic {IDLE, PUSH} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] hold_id;
  logic            grant_ok;
  logic            pick_write;
  logic            aw_hs, ar_hs;
  logic            done_ok;

`ifndef AXI_CMD_ARB_WR_PRIORITY_EN
  logic last_grant_write;  // 0 = READ, so the first contested grant goes to write
`endif

  assign grant_ok = (outst_cnt < 5'(MAX_OUTST));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_nxt   = state;
    awready     = 1'b0;
    arready     = 1'b0;
    cmd_valid   = 1'b0;
    id_write_en = 1'b0;
`ifdef AXI_CMD_ARB_WR_PRIORITY_EN
    pick_write  = awvalid;
`else
    pick_write  = awvalid & (~arvalid | ~last_grant_write);
`endif
    case (state)
      IDLE: begin
        awready = grant_ok & awvalid & pick_write;
        arready = grant_ok & arvalid & ~pick_write;
        if ((awvalid & awready) | (arvalid & arready)) state_nxt = PUSH;
      end
      PUSH: begin
        cmd_valid   = ~id_full;
        id_write_en = cmd_valid & cmd_ready;
        if (id_write_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign aw_hs   = awvalid & awready;
  assign ar_hs   = arvalid & arready;
  assign id_data = {cmd_write, hold_id};
  // A retire pulse with nothing in flight carries no information and is dropped.
  assign done_ok = txn_done & (outst_cnt != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
`ifndef AXI_CMD_ARB_WR_PRIORITY_EN
      last_grant_write <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
`ifndef AXI_CMD_ARB_WR_PRIORITY_EN
      if (aw_hs)      last_grant_write <= 1'b1;
      else if (ar_hs) last_grant_write <= 1'b0;
`endif
    end
  end

  // NOTE: hold registers are reset because they drive the cmd_* and id_data outputs directly.
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      hold_id   <= '0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      cmd_size  <= '0;
      cmd_burst <= '0;
      cmd_write <= 1'b0;
    end else if (aw_hs) begin
      hold_id   <= awid;
      cmd_addr  <= awaddr;
      cmd_len   <= awlen;
      cmd_size  <= awsize;
      cmd_burst <= awburst;
      cmd_write <= 1'b1;
    end else if (ar_hs) begin
      hold_id   <= arid;
      cmd_addr  <= araddr;
      cmd_len   <= arlen;
      cmd_size  <= arsize;
      cmd_burst <= arburst;
      cmd_write <= 1'b0;
    end
  end

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn)                    outst_cnt <= 5'd0;
    else if (id_write_en & ~done_ok) outst_cnt <= outst_cnt + 5'd1;
    else if (~id_write_en & done_ok) outst_cnt <= outst_cnt - 5'd1;
  end

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Self-checking bench for axi_cmd_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_axi_cmd_arbiter;
  localparam int ID_W = 8, ADDR_W = 32, MAX = 16;

  logic              wclk = 1'b0, resetn = 1'b0;
  logic [ID_W-1:0]   awid = '0, arid = '0;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic [3:0]        awlen = '0, arlen = '0;
  logic [2:0]        awsize = '0, arsize = '0;
  logic [1:0]        awburst = '0, arburst = '0;
  logic              awvalid = 1'b0, arvalid = 1'b0, awready, arready;
  logic [ID_W:0]     id_data;
  logic              id_write_en, id_full = 1'b0;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_len;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;
  logic              cmd_write, cmd_valid, cmd_ready = 1'b0, txn_done = 1'b0;
  logic [4:0]        outst_cnt;

  axi_cmd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .MAX_OUTST(MAX)) dut (
    .wclk(wclk), .resetn(resetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .id_data(id_data), .id_write_en(id_write_en), .id_full(id_full),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .cmd_write(cmd_write), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .txn_done(txn_done), .outst_cnt(outst_cnt)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    bit              w;
    logic [ID_W-1:0] id;
    logic [ADDR_W-1:0] addr;
    logic [3:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } txn_t;

  // Reference model: the single accepted-but-unpushed transaction, the in-flight count, and the last winner.
  txn_t pend[$];
  int   m_cnt;
  bit   m_last_w;
  bit   dut_log[$];  // channel the DUT actually granted, 1 = write
  int   n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit choose_write();
    if (!arvalid) return 1'b1;
    if (!awvalid) return 1'b0;
`ifdef AXI_CMD_ARB_WR_PRIORITY_EN
    return 1'b1;
`else
    return !m_last_w;
`endif
  endfunction

  // Called at a falling edge with inputs already driven; checks, then advances the model one clock.
  task automatic step();
    bit exp_awr, exp_arr, exp_cv, exp_wen, done_now;
    txn_t t;
    #1;
    exp_awr = 0; exp_arr = 0; exp_cv = 0; exp_wen = 0;
    if (pend.size() == 0) begin
      if (m_cnt < MAX && (awvalid || arvalid)) begin
        exp_awr = choose_write();
        exp_arr = !exp_awr;
      end
    end else begin
      t = pend[0];
      exp_cv  = !id_full;
      exp_wen = !id_full && cmd_ready;
      check("id_data",   id_data,   {t.w, t.id});
      check("cmd_addr",  cmd_addr,  t.addr);
      check("cmd_len",   cmd_len,   t.len);
      check("cmd_size",  cmd_size,  t.size);
      check("cmd_burst", cmd_burst, t.burst);
      check("cmd_write", cmd_write, t.w);
    end
    check("awready",     awready,     exp_awr);
    check("arready",     arready,     exp_arr);
    check("cmd_valid",   cmd_valid,   exp_cv);
    check("id_write_en", id_write_en, exp_wen);
    check("outst_cnt",   outst_cnt,   m_cnt);
    if (awvalid && awready) dut_log.push_back(1'b1);
    else if (arvalid && arready) dut_log.push_back(1'b0);
    done_now = txn_done;
    @(posedge wclk);
    if (exp_awr) begin
      t = '{1'b1, awid, awaddr, awlen, awsize, awburst};
      pend.push_back(t); m_last_w = 1'b1;
    end else if (exp_arr) begin
      t = '{1'b0, arid, araddr, arlen, arsize, arburst};
      pend.push_back(t); m_last_w = 1'b0;
    end
    m_cnt = m_cnt + (exp_wen ? 1 : 0) - ((done_now && m_cnt > 0) ? 1 : 0);
    if (exp_wen) void'(pend.pop_front());
    @(negedge wclk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    awvalid = 0; arvalid = 0; cmd_ready = 0; id_full = 0; txn_done = 0;
    #1;
    check("rst_awready",   awready, 0);
    check("rst_arready",   arready, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_wen",       id_write_en, 0);
    check("rst_id_data",   id_data, 0);
    check("rst_cmd_addr",  cmd_addr, 0);
    check("rst_cmd_misc",  {cmd_len, cmd_size, cmd_burst, cmd_write}, 0);
    check("rst_outst",     outst_cnt, 0);
    pend.delete(); dut_log.delete(); m_cnt = 0; m_last_w = 1'b0;
    @(negedge wclk);
    resetn = 1'b1;
  endtask

  task automatic rand_ids();
    awid = ID_W'($urandom); arid = ID_W'($urandom);
    awaddr = $urandom; araddr = $urandom;
    awlen = 4'($urandom); arlen = 4'($urandom);
    awsize = 3'($urandom); arsize = 3'($urandom);
    awburst = 2'($urandom); arburst = 2'($urandom);
  endtask

  initial begin
    int aw_left, ar_left, n;
    logic [3:0] order;

    do_reset();

    // Single write
    awid = 8'h5A; awaddr = 32'h1000; awlen = 4'd3; awsize = 3'd2; awburst = 2'd1;
    awvalid = 1; cmd_ready = 1;
    #1 check("single_awready", awready, 1);
    step();
    awvalid = 0;
    #1;
    check("single_wen", id_write_en, 1);
    check("single_id_data", id_data, 9'h15A);
    check("single_write", cmd_write, 1);
    check("single_addr", cmd_addr, 32'h1000);
    step();
    #1 check("single_cnt", outst_cnt, 1);
    step();

    // Contested grants from reset
    do_reset();
    cmd_ready = 1; aw_left = 2; ar_left = 2;
    for (int i = 0; i < 20 && (aw_left + ar_left) > 0; i++) begin
      rand_ids();
      awvalid = (aw_left > 0); arvalid = (ar_left > 0);
      n = dut_log.size();
      step();
      if (dut_log.size() > n) begin
        if (dut_log[$]) aw_left--; else ar_left--;
      end
    end
    awvalid = 0; arvalid = 0;
    check("grant_count", dut_log.size(), 4);
    order = '0;
    for (int i = 0; i < 4 && i < dut_log.size(); i++) order[3-i] = dut_log[i];
`ifdef AXI_CMD_ARB_WR_PRIORITY_EN
    check("grant_order", order, 4'b1100);
`else
    check("grant_order", order, 4'b1010);
`endif
    repeat (2) step();

    // Stall on id_full with a read held
    arid = 8'h22; araddr = 32'h2000; arvalid = 1; id_full = 0; cmd_ready = 1;
    step();
    arvalid = 0; id_full = 1;
    repeat (5) step();
    id_full = 0;
    #1;
    check("stall_id_data", id_data, 9'h022);
    check("stall_wen", id_write_en, 1);
    step();

    // Fill to the in-flight limit
    do_reset();
    cmd_ready = 1;
    for (int i = 0; i < 200 && m_cnt < MAX; i++) begin
      rand_ids();
      awvalid = 1'($urandom); arvalid = 1'($urandom);
      step();
    end
    check("fill_cnt", outst_cnt, 16);
    awvalid = 1; arvalid = 1;
    repeat (3) step();
    awvalid = 0; arvalid = 0; txn_done = 1;
    step();
    txn_done = 0; awvalid = 1;
    #1;
    check("drain_cnt", outst_cnt, 15);
    check("drain_grant", awready, 1);
    step();
    awvalid = 0;
    repeat (2) step();

    // Push coinciding with a retire
    do_reset();
    cmd_ready = 1;
    for (int i = 0; i < 100 && m_cnt < 7; i++) begin
      rand_ids();
      awvalid = (m_cnt + pend.size() < 7); arvalid = 0;
      step();
    end
    awvalid = 1;
    step();
    awvalid = 0; txn_done = 1;
    step();
    txn_done = 0;
    #1 check("push_done_cnt", outst_cnt, 7);
    step();

    // Reset while a command is held
    do_reset();
    cmd_ready = 1; awvalid = 1; rand_ids();
    step();
    awvalid = 0;
    step();
    arvalid = 1; cmd_ready = 0;
    step();
    arvalid = 0;
    step();
    do_reset();
    awvalid = 1; arvalid = 1; cmd_ready = 1;
    #1;
    check("post_rst_aw", awready, 1);
    check("post_rst_ar", arready, 0);
    step();
    awvalid = 0; arvalid = 0;
    step();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rand_ids();
      awvalid   = 1'($urandom);
      arvalid   = 1'($urandom);
      cmd_ready = ($urandom_range(0, 3) != 0);
      id_full   = ($urandom_range(0, 4) == 0);
      txn_done  = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
